// File: rtl/dct_stream_core.sv
// Sample-serial N-point integer DCT-II: buffers N signed samples, then computes each
// coefficient with one shared MAC and presents it with a valid/ready handshake.
module dct_stream_core #(
   parameter int N      = 8,
   parameter int IN_W   = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 12,
   parameter int SHIFT  = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cs,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic [$clog2(N)-1:0]    out_index,
   output logic                    out_last,
   output logic                    busy
);

   localparam int KW     = $clog2(N);
   localparam int PROD_W = IN_W + COEF_W;
   localparam int ACC_W  = IN_W + COEF_W + KW;
   localparam int EXT_W  = ACC_W + OUT_W;
   localparam int S      = 2 ** (COEF_W - 2);
   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

   // Angle is folded into [0, pi/2] by quadrant symmetry, so a short Taylor series is exact
   // enough; magnitude is rounded half-up and the sign applied after (half away from zero).
   function automatic int cos_scaled(input int k, input int n);
      int  q;
      int  r;
      bit  neg;
      real th, term, sum;
      q = ((2 * n + 1) * k) % (4 * N);
      if (q > 2 * N) q = 4 * N - q;
      neg = 1'b0;
      if (q > N) begin
         q   = 2 * N - q;
         neg = 1'b1;
      end
      th   = 3.14159265358979323846 * real'(q) / real'(2 * N);
      sum  = 1.0;
      term = 1.0;
      for (int unsigned i = 1; i <= 14; i++) begin
         term = -term * th * th / real'((2 * i - 1) * (2 * i));
         sum  = sum + term;
      end
      r = $rtoi(real'(S) * sum + 0.5);
      return neg ? -r : r;
   endfunction

   logic signed [COEF_W-1:0] rom [N*N];

   for (genvar gk = 0; gk < N; gk++) begin : g_k
      for (genvar gn = 0; gn < N; gn++) begin : g_n
         localparam logic signed [COEF_W-1:0] CV = COEF_W'(cos_scaled(gk, gn));
         assign rom[gk*N+gn] = CV;
      end
   end

   typedef enum logic [1:0] {S_FILL, S_COMPUTE, S_OUTPUT} state_t;

   state_t                    state_q, state_d;
   logic [KW-1:0]             n_q, k_q;
   logic [KW:0]               m_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic [OUT_W-1:0]          data_q;
   logic signed [IN_W-1:0]    buf_q [N];

   logic                      in_ready_c, out_valid_c, accept, mac_en, finalize, out_hs;
   logic signed [PROD_W-1:0]  prod;
   logic signed [EXT_W-1:0]   sh_ext;
   logic [OUT_W-1:0]          sat_c;

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      accept      = 1'b0;
      mac_en      = 1'b0;
      finalize    = 1'b0;
      out_hs      = 1'b0;
      case (state_q)
         S_FILL: begin
            in_ready_c = cs;
            accept     = in_valid && cs;
            if (accept && n_q == KW'(N - 1)) state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            // Extra cycle after the last term registers the saturated result.
            if (m_q == (KW+1)'(N)) begin
               finalize = 1'b1;
               state_d  = S_OUTPUT;
            end else begin
               mac_en = 1'b1;
            end
         end
         S_OUTPUT: begin
            out_valid_c = 1'b1;
            if (out_ready) begin
               out_hs  = 1'b1;
               state_d = (k_q == KW'(N - 1)) ? S_FILL : S_COMPUTE;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      prod   = rom[{k_q, m_q[KW-1:0]}] * buf_q[m_q[KW-1:0]];
      sh_ext = EXT_W'(acc_q >>> SHIFT);
      if (sh_ext > SAT_MAX)      sat_c = SAT_MAX[OUT_W-1:0];
      else if (sh_ext < SAT_MIN) sat_c = SAT_MIN[OUT_W-1:0];
      else                       sat_c = sh_ext[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         n_q     <= '0;
         k_q     <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            buf_q[n_q] <= in_data;
            n_q        <= n_q + KW'(1);
            if (n_q == KW'(N - 1)) begin
               k_q   <= '0;
               m_q   <= '0;
               acc_q <= '0;
            end
         end
         if (mac_en) begin
            acc_q <= acc_q + ACC_W'(prod);
            m_q   <= m_q + (KW+1)'(1);
         end
         if (finalize) data_q <= sat_c;
         if (out_hs) begin
            if (k_q == KW'(N - 1)) begin
               n_q <= '0;
            end else begin
               k_q   <= k_q + KW'(1);
               m_q   <= '0;
               acc_q <= '0;
            end
         end
      end
   end

   // Outputs are gated so they read as reset values for the whole time rst is high.
   assign in_ready  = in_ready_c & ~rst;
   assign out_valid = out_valid_c & ~rst;
   assign busy      = (state_q != S_FILL) & ~rst;
   assign out_data  = rst ? '0 : data_q;
   assign out_index = rst ? '0 : k_q;
   assign out_last  = out_valid_c & (k_q == KW'(N - 1)) & ~rst;

endmodule

// File: tb/tb_dct_stream_core.sv
// Directed/randomized bench for dct_stream_core: two N=8 instances (OUT_W 12 and 10) share
// stimulus; an N=16 instance is exercised separately. Results compared to a cosine model.
module tb_dct_stream_core;

   logic        clk = 1'b0;
   logic        rst, cs, in_valid, out_ready, sel;
   logic [7:0]  in_data;
   int          tests = 0;
   int          fails = 0;
   int          nn = 8;
   int          xs [32];

   logic        a_iv, c_iv, a_or, c_or;
   logic        a_in_ready, a_out_valid, a_out_last, a_busy;
   logic [11:0] a_out_data;
   logic [2:0]  a_out_index;
   logic        b_in_ready, b_out_valid, b_out_last, b_busy;
   logic [9:0]  b_out_data;
   logic [2:0]  b_out_index;
   logic        c_in_ready, c_out_valid, c_out_last, c_busy;
   logic [11:0] c_out_data;
   logic [3:0]  c_out_index;

   always #5 clk = ~clk;

   assign a_iv = in_valid & ~sel;
   assign c_iv = in_valid & sel;
   assign a_or = out_ready & ~sel;
   assign c_or = out_ready & sel;

   dct_stream_core #(.N(8), .IN_W(8), .COEF_W(8), .OUT_W(12), .SHIFT(6)) dut_a (
      .clk(clk), .rst(rst), .cs(cs), .in_valid(a_iv), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(a_or), .out_data(a_out_data), .out_index(a_out_index),
      .out_last(a_out_last), .busy(a_busy));

   dct_stream_core #(.N(8), .IN_W(8), .COEF_W(8), .OUT_W(10), .SHIFT(6)) dut_b (
      .clk(clk), .rst(rst), .cs(cs), .in_valid(a_iv), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(a_or), .out_data(b_out_data), .out_index(b_out_index),
      .out_last(b_out_last), .busy(b_busy));

   dct_stream_core #(.N(16), .IN_W(8), .COEF_W(8), .OUT_W(12), .SHIFT(6)) dut_c (
      .clk(clk), .rst(rst), .cs(cs), .in_valid(c_iv), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(c_or), .out_data(c_out_data), .out_index(c_out_index),
      .out_last(c_out_last), .busy(c_busy));

   logic        v_in_ready, v_out_valid, v_out_last, v_busy;
   logic [11:0] v_out_data;
   int          v_out_index;
   assign v_in_ready  = sel ? c_in_ready  : a_in_ready;
   assign v_out_valid = sel ? c_out_valid : a_out_valid;
   assign v_out_last  = sel ? c_out_last  : a_out_last;
   assign v_busy      = sel ? c_busy      : a_busy;
   assign v_out_data  = sel ? c_out_data  : a_out_data;
   assign v_out_index = sel ? int'(c_out_index) : int'(a_out_index);

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Z[k] from the DCT-II definition with scale 64, floor shift by 6 and saturation.
   function automatic longint model(input int n_pts, input int outw, input int k);
      longint acc, c, lim;
      real    v;
      acc = 0;
      for (int n = 0; n < n_pts; n++) begin
         v = 64.0 * $cos(3.14159265358979 * (2 * n + 1) * k / (2.0 * n_pts));
         c = (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
         acc += c * xs[n];
      end
      acc = acc >>> 6;
      lim = (longint'(1) <<< (outw - 1)) - 1;
      if (acc > lim) acc = lim;
      if (acc < -lim - 1) acc = -lim - 1;
      return acc;
   endfunction

   task automatic fill(input int cs_gap_at);
      int guard;
      for (int i = 0; i < nn; i++) begin
         if (i == cs_gap_at) begin
            cs       = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'(xs[i]);
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               chk("cs_low_in_ready", longint'(v_in_ready), 0);
               @(posedge clk); #1;
            end
            cs = 1'b1;
         end
         in_valid = 1'b1;
         in_data  = 8'(xs[i]);
         guard    = 0;
         forever begin
            @(negedge clk);
            if (v_in_ready) begin
               @(posedge clk); #1;
               break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 400) begin
               chk("fill_timeout", 0, 1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   // Collects ncoef coefficients; with hold_last the last one is left pending (out_ready low).
   task automatic recv(input int ncoef, input int bp_k, input bit hold_last);
      int          cnt;
      logic [11:0] held;
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      out_ready = 1'b1;
      for (int k = 0; k < ncoef; k++) begin
         cnt = 0;
         forever begin
            @(negedge clk);
            if (v_out_valid) break;
            @(posedge clk); #1;
            cnt++;
            if (cnt > 400) break;
         end
         chk("latency", cnt, nn + 1);
         chk("out_data", longint'($signed(v_out_data)), model(nn, 12, k));
         if (!sel) chk("out_data_w10", longint'($signed(b_out_data)), model(nn, 10, k));
         chk("out_index", v_out_index, k);
         chk("out_last", longint'(v_out_last), (k == nn - 1) ? 1 : 0);
         chk("in_ready_busy", longint'(v_in_ready), 0);
         chk("busy", longint'(v_busy), 1);
         if (hold_last && k == ncoef - 1) begin
            out_ready = 1'b0;
            in_valid  = 1'b0;
            return;
         end
         if (k == bp_k) begin
            out_ready = 1'b0;
            held      = v_out_data;
            for (int j = 0; j < 5; j++) begin
               @(posedge clk); #1;
               @(negedge clk);
               chk("bp_valid", longint'(v_out_valid), 1);
               chk("bp_data", longint'(v_out_data), longint'(held));
               chk("bp_index", v_out_index, k);
               chk("bp_last", longint'(v_out_last), (k == nn - 1) ? 1 : 0);
               chk("bp_in_ready", longint'(v_in_ready), 0);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, longint'(v_in_ready), 0);
      chk({tag, "_out_valid"}, longint'(v_out_valid), 0);
      chk({tag, "_out_data"}, longint'(v_out_data), 0);
      chk({tag, "_out_index"}, v_out_index, 0);
      chk({tag, "_out_last"}, longint'(v_out_last), 0);
      chk({tag, "_busy"}, longint'(v_busy), 0);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs(tag);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk({tag, "_after_in_ready"}, longint'(v_in_ready), 1);
      chk({tag, "_after_busy"}, longint'(v_busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic set_const(input int v);
      for (int i = 0; i < 32; i++) xs[i] = v;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 32; i++) xs[i] = int'($urandom_range(255)) - 128;
   endtask

   initial begin
      rst = 1'b1; cs = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; in_data = '0;
      set_const(0);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_reset", longint'(v_in_ready), 1);
      @(posedge clk); #1;

      set_const(10);   fill(-1); recv(8, -1, 1'b0);
      set_const(0); xs[0] = 64; fill(-1); recv(8, -1, 1'b0);
      set_const(-10);  fill(-1); recv(8, -1, 1'b0);
      set_const(127);  fill(-1); recv(8, -1, 1'b0);
      set_const(-128); fill(-1); recv(8, -1, 1'b0);
      set_rand();      fill(-1); recv(8, 3, 1'b0);
      set_rand();      fill(3);  recv(8, -1, 1'b0);

      set_rand(); fill(-1);
      repeat (4) @(posedge clk);
      #1;
      pulse_reset("rst_compute");
      set_rand(); fill(-1); recv(3, -1, 1'b1);
      @(posedge clk); #1;
      pulse_reset("rst_output");
      set_rand(); fill(-1); recv(8, -1, 1'b0);
      for (int b = 0; b < 3; b++) begin
         set_rand(); fill(-1); recv(8, -1, 1'b0);
      end

      sel = 1'b1; nn = 16;
      set_const(5);  fill(-1); recv(16, -1, 1'b0);
      set_rand();    fill(-1); recv(16, 7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
